fir_out_quant: RTL

//   Output end of the cascaded-DSP FIR chain. Aligns a sample-valid strobe with the
//   FIR pipeline latency and captures the 54-bit signed accumulator. Rounds, shifts and

---
 rtl/fir_pkg.sv | 11 +
 rtl/fir_out_fifo.sv | 51 +++++
 rtl/fir_out_quant.sv | 115 +++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Types and limits shared by the FIR datapath and its output quantiser.
package fir_pkg;
  localparam int SAMPLE_W = 18;
  localparam int ACC_W    = 54;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  localparam sample_t SAMPLE_MAX = sample_t'((64'sd1 <<< (SAMPLE_W-1)) - 64'sd1);
  localparam sample_t SAMPLE_MIN = sample_t'(-(64'sd1 <<< (SAMPLE_W-1)));
endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty derived from an occupancy count.
module fir_out_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr;
  logic             rd;

  assign valid = (count != '0);
  assign full  = (count == DEPTH_CNT);
  assign rd    = pop && valid;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr    = push && (!full || rd);
  assign dout  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fir_out_quant.sv
// FIR output end: latency-aligned capture, half-up round, shift, saturate, FIFO to stream.
module fir_out_quant
  import fir_pkg::*;
#(
  parameter int IN_W       = ACC_W,
  parameter int OUT_W      = SAMPLE_W,
  parameter int SHIFT      = 17,
  parameter int LAT        = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  acc,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun,
  output logic [15:0]             sat_cnt,
  input  logic                    clr_stat
);
  localparam int R_W = IN_W + 1 - SHIFT;
  localparam logic signed [IN_W:0]  HALF  = (IN_W+1)'(1) << (SHIFT-1);
  localparam logic signed [R_W-1:0] R_MAX = R_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [R_W-1:0] R_MIN = R_W'(-(64'sd1 <<< (OUT_W-1)));

  // One guard bit above the accumulator keeps the rounding add from wrapping.
  function automatic logic signed [R_W-1:0] round_shift(input logic signed [IN_W-1:0] a);
    logic signed [IN_W:0] s;
    s = $signed({a[IN_W-1], a}) + HALF;
    return s[IN_W:SHIFT];
  endfunction

  function automatic logic [OUT_W:0] saturate(input logic signed [R_W-1:0] r);
    if (r > R_MAX) return {1'b1, R_MAX[OUT_W-1:0]};
    if (r < R_MIN) return {1'b1, R_MIN[OUT_W-1:0]};
    return {1'b0, r[OUT_W-1:0]};
  endfunction

  logic [LAT-1:0]          vld_dly;
  logic                    vld_p0;
  logic signed [R_W-1:0]   r_p1;
  logic                    vld_p1;
  logic [OUT_W:0]          q_p1;
  logic signed [OUT_W-1:0] data_p2;
  logic                    sat_p2;
  logic                    vld_p2;
  logic [OUT_W:0]          head;
  logic                    fifo_full;

  // p0: in_valid delayed to line up with the matching accumulator value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_dly <= '0;
    else     vld_dly <= (vld_dly << 1) | LAT'(in_valid);
  end
  assign vld_p0 = vld_dly[LAT-1];

  // p1: round and shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      r_p1   <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) r_p1 <= round_shift(acc);
    end
  end
  assign q_p1 = saturate(r_p1);

  // p2: saturate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      sat_p2  <= 1'b0;
      data_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        sat_p2  <= q_p1[OUT_W];
        data_p2 <= q_p1[OUT_W-1:0];
      end
    end
  end

  fir_out_fifo #(
    .WIDTH(OUT_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (vld_p2),
    .din  ({sat_p2, data_p2}),
    .pop  (out_ready),
    .dout (head),
    .valid(out_valid),
    .full (fifo_full)
  );

  assign out_sat  = head[OUT_W];
  assign out_data = head[OUT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
      sat_cnt <= '0;
    end else if (clr_stat) begin
      overrun <= 1'b0;
      sat_cnt <= '0;
    end else begin
      if (vld_p2 && fifo_full && !out_ready) overrun <= 1'b1;
      if (vld_p2 && sat_p2 && (sat_cnt != 16'hFFFF)) sat_cnt <= sat_cnt + 16'd1;
    end
  end
endmodule
